// File: rtl/mdio_arbiter.sv
// mdio_arbiter -- two-requester MDIO (clause 22) management master.
//
// Two requesters compete for a single MDIO bus. Arbitration happens only while
// idle and only in a clk cycle in which MDC falls. A ready pulse grants one
// requester. The block then serialises one frame: an optional preamble, a
// 14-bit header, turnaround, 16 data bits, then a one-bit gap. The owner gets a
// single-cycle response pulse carrying the read data, which is 0 for writes.
//
// Optional feature: define MDIO_PREAMBLE_EN to send a 32-bit all-ones preamble
// before each header (a frame is then 65 MDC periods). Without it, frames start
// directly with the header (33 MDC periods).
//
// Parameter
//   MDC_DIV        clk cycles per MDC half-period (2..255)
// Ports
//   clk, reset     core clock; asynchronous active-high reset
//   reqN_valid     requester N has a transaction pending (N = 0, 1)
//   reqN_ready     one-cycle grant pulse
//   reqN_wr        1 = write, 0 = read
//   reqN_phy/reg   PHY and register addresses
//   reqN_wdata     write data
//   rspN_valid     one-cycle completion pulse
//   rspN_rdata     read data (0 for writes), valid with rspN_valid
//   phy_mdc        management clock, free running
//   phy_mdio_out   serial data towards the pad
//   phy_mdio_tri   1 = drive phy_mdio_out onto the pad, 0 = release it
//   phy_mdio_in    pad input
//   busy           high from the grant until the response pulse
//
// Handshake: a requester raises reqN_valid with its fields stable and holds
// them until it sees reqN_ready. The transaction is accepted in the cycle in
// which both are high. The fields are captured on the edge that raises ready,
// so they are don't-care from the ready cycle onward. Ready never pulses twice
// for one transaction, and a request that arrives while busy simply waits.
module mdio_arbiter #(
    parameter int MDC_DIV = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_wr,
    input  logic [4:0]  req0_phy,
    input  logic [4:0]  req0_reg,
    input  logic [15:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_rdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_wr,
    input  logic [4:0]  req1_phy,
    input  logic [4:0]  req1_reg,
    input  logic [15:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_rdata,
    output logic        phy_mdc,
    output logic        phy_mdio_out,
    output logic        phy_mdio_tri,
    input  logic        phy_mdio_in,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(MDC_DIV - 1);

    // ------------------------------------------------------------------
    // MDC generator. The tick cycle is the last cycle of a half-period.
    // phy_mdc toggles on the edge that ends a tick cycle. So a tick with
    // MDC high is the cycle whose closing edge makes MDC fall, and every
    // pad change is registered on that same edge. A tick with MDC low
    // samples the pad on the edge that makes MDC rise.
    // ------------------------------------------------------------------
    logic [7:0] div_cnt;
    logic       tick;
    logic       mdc_fall;
    logic       mdc_rise;

    assign tick     = (div_cnt == DIV_LAST);
    assign mdc_fall = tick & phy_mdc;
    assign mdc_rise = tick & ~phy_mdc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 8'd0;
            phy_mdc <= 1'b0;
        end else if (tick) begin
            div_cnt <= 8'd0;
            phy_mdc <= ~phy_mdc;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin selection. last_served = 1 means requester 1 was served
    // last. It resets to 1 so that requester 0 wins the first contest.
    // ------------------------------------------------------------------
    logic        last_served;
    logic        pick1;
    logic        sel_wr;
    logic [4:0]  sel_phy;
    logic [4:0]  sel_reg;
    logic [15:0] sel_wdata;
    logic [13:0] sel_hdr;

    always_comb begin
        pick1     = req1_valid && (!req0_valid || !last_served);
        sel_wr    = pick1 ? req1_wr    : req0_wr;
        sel_phy   = pick1 ? req1_phy   : req0_phy;
        sel_reg   = pick1 ? req1_reg   : req0_reg;
        sel_wdata = pick1 ? req1_wdata : req0_wdata;
        // ST=01, OP=01 write / 10 read, PHY, REG -- sent MSB first
        sel_hdr   = {2'b01, (sel_wr ? 2'b01 : 2'b10), sel_phy, sel_reg};
    end

    // ------------------------------------------------------------------
    // Frame FSM. The state and count name the bit currently on the wire.
    // Each MDC fall either advances within the state or moves to the
    // first bit of the next state.
    // ------------------------------------------------------------------
    state_t      state;
    logic [4:0]  bit_cnt;
    logic        own;       // requester that owns the current frame
    logic        wr_q;
    logic [15:0] wdata_q;
    logic [15:0] tx_sh;     // header bits still to send, MSB next
    logic [15:0] rx_sh;     // read data, shifted in MSB first

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= 5'd0;
            own          <= 1'b0;
            last_served  <= 1'b1;
            wr_q         <= 1'b0;
            wdata_q      <= 16'd0;
            tx_sh        <= 16'd0;
            rx_sh        <= 16'd0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_rdata   <= 16'd0;
            rsp1_rdata   <= 16'd0;
            phy_mdio_out <= 1'b1;
            phy_mdio_tri <= 1'b0;
            busy         <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            // busy stays up through the response cycle itself
            if (rsp0_valid || rsp1_valid) begin
                busy <= 1'b0;
            end

            if (mdc_rise && state == DATA && !wr_q) begin
                rx_sh <= {rx_sh[14:0], phy_mdio_in};
            end

            if (mdc_fall) begin
                case (state)
                    IDLE: begin
                        if (req0_valid || req1_valid) begin
                            own          <= pick1;
                            last_served  <= pick1;
                            req0_ready   <= ~pick1;
                            req1_ready   <= pick1;
                            busy         <= 1'b1;
                            wr_q         <= sel_wr;
                            wdata_q      <= sel_wdata;
                            bit_cnt      <= 5'd0;
                            phy_mdio_tri <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
                            state        <= PRE;
                            phy_mdio_out <= 1'b1;
                            tx_sh        <= {sel_hdr, 2'b00};
`else
                            state        <= HDR;
                            phy_mdio_out <= sel_hdr[13];
                            tx_sh        <= {sel_hdr[12:0], 3'b000};
`endif
                        end
                    end
                    PRE: begin
                        if (bit_cnt == 5'd31) begin
                            state        <= HDR;
                            bit_cnt      <= 5'd0;
                            phy_mdio_out <= tx_sh[15];
                            tx_sh        <= {tx_sh[14:0], 1'b0};
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    HDR: begin
                        if (bit_cnt == 5'd13) begin
                            state        <= TA;
                            bit_cnt      <= 5'd0;
                            // write: first TA bit is 1; read: release the pad
                            phy_mdio_tri <= wr_q;
                            phy_mdio_out <= 1'b1;
                        end else begin
                            bit_cnt      <= bit_cnt + 5'd1;
                            phy_mdio_out <= tx_sh[15];
                            tx_sh        <= {tx_sh[14:0], 1'b0};
                        end
                    end
                    TA: begin
                        if (bit_cnt == 5'd1) begin
                            state        <= DATA;
                            bit_cnt      <= 5'd0;
                            phy_mdio_out <= wr_q ? wdata_q[15] : 1'b1;
                            tx_sh        <= {wdata_q[14:0], 1'b0};
                        end else begin
                            bit_cnt      <= bit_cnt + 5'd1;
                            phy_mdio_out <= wr_q ? 1'b0 : 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == 5'd15) begin
                            state        <= GAP;
                            bit_cnt      <= 5'd0;
                            phy_mdio_tri <= 1'b0;
                            phy_mdio_out <= 1'b1;
                            // the last read sample was taken at the preceding rise
                            if (own) begin
                                rsp1_valid <= 1'b1;
                                rsp1_rdata <= wr_q ? 16'd0 : rx_sh;
                            end else begin
                                rsp0_valid <= 1'b1;
                                rsp0_rdata <= wr_q ? 16'd0 : rx_sh;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (wr_q) begin
                                phy_mdio_out <= tx_sh[15];
                                tx_sh        <= {tx_sh[14:0], 1'b0};
                            end
                        end
                    end
                    GAP: begin
                        state        <= IDLE;
                        phy_mdio_tri <= 1'b0;
                        phy_mdio_out <= 1'b1;
                    end
                    default: begin
                        state        <= IDLE;
                        phy_mdio_tri <= 1'b0;
                        phy_mdio_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Testbench for mdio_arbiter. It builds the expected pad sequence for each
// frame from the frame layout, and emulates a PHY that answers reads. It tracks
// grants and responses per requester. Compile with MDIO_PREAMBLE_EN defined or
// undefined to match the RTL build.
module tb_mdio_arbiter;

    localparam int MDC_DIV = 13;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE_BITS = 32;
`else
    localparam int PRE_BITS = 0;
`endif
    localparam int FRAME_BITS = PRE_BITS + 33;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic        req_valid [2];
    logic        req_wr    [2];
    logic [4:0]  req_phy   [2];
    logic [4:0]  req_reg   [2];
    logic [15:0] req_wdata [2];
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_rdata, rsp1_rdata;
    logic        phy_mdc, phy_mdio_out, phy_mdio_tri, busy;
    logic        phy_mdio_in = 1'b1;

    logic        ready_v [2];
    logic        rsp_v   [2];
    logic [15:0] rdata_v [2];
    assign ready_v[0] = req0_ready;
    assign ready_v[1] = req1_ready;
    assign rsp_v[0]   = rsp0_valid;
    assign rsp_v[1]   = rsp1_valid;
    assign rdata_v[0] = rsp0_rdata;
    assign rdata_v[1] = rsp1_rdata;

    mdio_arbiter #(.MDC_DIV(MDC_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req_valid[0]),
        .req0_ready   (req0_ready),
        .req0_wr      (req_wr[0]),
        .req0_phy     (req_phy[0]),
        .req0_reg     (req_reg[0]),
        .req0_wdata   (req_wdata[0]),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .req1_valid   (req_valid[1]),
        .req1_ready   (req1_ready),
        .req1_wr      (req_wr[1]),
        .req1_phy     (req_phy[1]),
        .req1_reg     (req_reg[1]),
        .req1_wdata   (req_wdata[1]),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .phy_mdc      (phy_mdc),
        .phy_mdio_out (phy_mdio_out),
        .phy_mdio_tri (phy_mdio_tri),
        .phy_mdio_in  (phy_mdio_in),
        .busy         (busy)
    );

    int checks = 0;
    int passed = 0;

    // ---------------- transaction monitor ----------------
    int          cyc = 0;
    int          ready_cnt [2] = '{0, 0};
    int          rsp_cnt   [2] = '{0, 0};
    int          last_ready_cyc [2] = '{0, 0};
    int          last_rsp_cyc   [2] = '{0, 0};
    int          busy_viol = 0;
    int          dual_ready = 0;
    bit          in_txn = 1'b0;
    int          owner = 0;
    int          grant_q[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_txn = 1'b0;
        end else begin
            if (in_txn && !busy) busy_viol++;
            if (ready_v[0] && ready_v[1]) dual_ready++;
            for (int i = 0; i < 2; i++) begin
                if (ready_v[i]) begin
                    ready_cnt[i]++;
                    last_ready_cyc[i] = cyc;
                    grant_q.push_back(i);
                    owner  = i;
                    in_txn = 1'b1;
                end
                if (rsp_v[i]) begin
                    rsp_cnt[i]++;
                    last_rsp_cyc[i] = cyc;
                    in_txn = 1'b0;
                end
            end
        end
    end

    // ---------------- PHY model ----------------
    // Counts the MDC periods the master has left the pad released. Periods
    // 1-2 are turnaround, and 3..18 carry the answer MSB first. The answer
    // changes just after MDC falls, so it is stable at the next rise.
    logic [15:0] phy_word [2] = '{16'h0, 16'h0};
    int          rel_cnt = 0;
    logic        model_prev_mdc = 1'b0;
    logic [15:0] cur_word;

    always @(negedge clk) begin
        if (model_prev_mdc && !phy_mdc) begin
            if (phy_mdio_tri) rel_cnt = 0;
            else if (rel_cnt < 100) rel_cnt++;
            cur_word = phy_word[owner];
            if (rel_cnt >= 3 && rel_cnt <= 18) phy_mdio_in = cur_word[18 - rel_cnt];
            else phy_mdio_in = 1'b1;
        end
        model_prev_mdc = phy_mdc;
    end

    // ---------------- driver helpers ----------------
    task automatic wait_mdc_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        prev = phy_mdc;
        for (int i = 0; i < 4 * MDC_DIV; i++) begin
            @(negedge clk);
            if (phy_mdc && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = phy_mdc;
        end
    endtask

    // One full transaction for requester n. It compares every pad bit
    // against the frame layout, then checks the response.
    task automatic do_txn(input int n, input bit wr, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] wd,
                          input logic [15:0] rd);
        logic [2:0]  exp_q[$];   // {care_out, tri, out}
        logic [13:0] h;
        logic [2:0]  e;
        int r0, q0, err, first_bad, diff;
        bit got, ok;
        logic bad_tri, bad_out;
        logic [15:0] want_rdata;

        for (int i = 0; i < PRE_BITS; i++) exp_q.push_back(3'b111);
        h = {2'b01, (wr ? 2'b01 : 2'b10), phy, ra};
        for (int i = 13; i >= 0; i--) exp_q.push_back({2'b11, h[i]});
        if (wr) begin
            exp_q.push_back(3'b111);
            exp_q.push_back(3'b110);
            for (int i = 15; i >= 0; i--) exp_q.push_back({2'b11, wd[i]});
        end else begin
            for (int i = 0; i < 18; i++) exp_q.push_back(3'b000);
        end
        exp_q.push_back(3'b101);

        r0 = rsp_cnt[n];
        q0 = ready_cnt[n];
        phy_word[n]  = rd;
        req_wr[n]    = wr;
        req_phy[n]   = phy;
        req_reg[n]   = ra;
        req_wdata[n] = wd;
        req_valid[n] = 1'b1;

        got = 1'b0;
        for (int i = 0; i < 400 * MDC_DIV; i++) begin
            @(negedge clk);
            if (ready_v[n]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            $display("FAIL grant_timeout req%0d: ready=0, required 1", n);
            req_valid[n] = 1'b0;
            return;
        end
        passed++;
        // accepted this cycle: withdraw and scramble the fields
        req_valid[n] = 1'b0;
        req_wr[n]    = 1'($urandom);
        req_phy[n]   = 5'($urandom);
        req_reg[n]   = 5'($urandom);
        req_wdata[n] = 16'($urandom);

        err = 0;
        first_bad = -1;
        bad_tri = 1'b0;
        bad_out = 1'b0;
        e = 3'b000;
        for (int k = 0; k < exp_q.size(); k++) begin
            wait_mdc_rise(ok);
            if (!ok) begin
                err++;
                if (first_bad < 0) first_bad = k;
                break;
            end
            if (phy_mdio_tri !== exp_q[k][1] ||
                (exp_q[k][2] && phy_mdio_out !== exp_q[k][0])) begin
                err++;
                if (first_bad < 0) begin
                    first_bad = k;
                    bad_tri = phy_mdio_tri;
                    bad_out = phy_mdio_out;
                    e = exp_q[k];
                end
            end
        end
        checks++;
        if (err != 0)
            $display("FAIL frame_bits req%0d: %0d bad bits, first at %0d got tri=%b out=%b, required tri=%b out=%b",
                     n, err, first_bad, bad_tri, bad_out, e[1], e[0]);
        else passed++;

        checks++;
        if (rsp_cnt[n] - r0 !== 1)
            $display("FAIL rsp_pulses req%0d: got %0d, required 1", n, rsp_cnt[n] - r0);
        else passed++;

        checks++;
        if (ready_cnt[n] - q0 !== 1)
            $display("FAIL ready_pulses req%0d: got %0d, required 1", n, ready_cnt[n] - r0 * 0 - q0);
        else passed++;

        want_rdata = wr ? 16'h0000 : rd;
        checks++;
        if (rdata_v[n] !== want_rdata)
            $display("FAIL rsp_rdata req%0d: got %h, required %h", n, rdata_v[n], want_rdata);
        else passed++;

        // the response comes one MDC fall before the GAP rise, i.e. FRAME_BITS-1
        // MDC periods after the fall that started the frame
        diff = last_rsp_cyc[n] - last_ready_cyc[n];
        checks++;
        if (diff !== (FRAME_BITS - 1) * 2 * MDC_DIV)
            $display("FAIL rsp_timing req%0d: got %0d cycles, required %0d",
                     n, diff, (FRAME_BITS - 1) * 2 * MDC_DIV);
        else passed++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int k;
        bit seen;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({phy_mdc, phy_mdio_out, phy_mdio_tri, busy} !== 4'b0100)
            $display("FAIL reset_pad: got mdc/out/tri/busy=%b, required 0100",
                     {phy_mdc, phy_mdio_out, phy_mdio_tri, busy});
        else passed++;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000)
            $display("FAIL reset_handshake: got rdy0/rdy1/rsp0/rsp1=%b, required 0000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        else passed++;
        checks++;
        if ({rsp0_rdata, rsp1_rdata} !== 32'h0)
            $display("FAIL reset_rdata: got %h, required 0", {rsp0_rdata, rsp1_rdata});
        else passed++;

        reset = 1'b0;
        // first rise: MDC starts low and toggles after MDC_DIV cycles
        k = 0;
        seen = 1'b0;
        for (int i = 1; i <= 4 * MDC_DIV; i++) begin
            @(negedge clk);
            if (phy_mdc) begin
                k = i;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || k != MDC_DIV)
            $display("FAIL mdc_first_rise: got %0d cycles, required %0d", k, MDC_DIV);
        else passed++;
        // high half, then full period to the next rise
        k = 0;
        seen = 1'b0;
        for (int i = 1; i <= 4 * MDC_DIV; i++) begin
            @(negedge clk);
            if (!phy_mdc) begin
                k = i;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || k != MDC_DIV)
            $display("FAIL mdc_high_time: got %0d cycles, required %0d", k, MDC_DIV);
        else passed++;
        for (int i = 1; i <= 4 * MDC_DIV; i++) begin
            @(negedge clk);
            if (phy_mdc) begin
                k = k + i;
                break;
            end
        end
        checks++;
        if (k != 2 * MDC_DIV)
            $display("FAIL mdc_period: got %0d cycles, required %0d", k, 2 * MDC_DIV);
        else passed++;
    endtask

    task automatic test_write_directed();
        do_txn(0, 1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000);
    endtask

    task automatic test_read_directed();
        do_txn(1, 1'b0, 5'h04, 5'h01, 16'h0000, 16'h796D);
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            do_txn($urandom_range(0, 1), 1'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int bv0, dr0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = grant_q.size();
        bv0 = busy_viol;
        dr0 = dual_ready;
        fork
            begin
                for (int t = 0; t < 3; t++)
                    do_txn(0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
            end
            begin
                for (int t = 0; t < 3; t++)
                    do_txn(1, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
            end
        join
        checks++;
        if (grant_q.size() - base != 6)
            $display("FAIL rr_grant_count: got %0d, required 6", grant_q.size() - base);
        else begin
            passed++;
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (grant_q[base + k] != (k % 2))
                    $display("FAIL rr_order grant %0d: got req%0d, required req%0d",
                             k, grant_q[base + k], k % 2);
                else passed++;
            end
        end
        checks++;
        if (busy_viol - bv0 != 0)
            $display("FAIL busy_hold: got %0d low cycles inside transactions, required 0", busy_viol - bv0);
        else passed++;
        checks++;
        if (dual_ready - dr0 != 0)
            $display("FAIL dual_ready: got %0d cycles with both ready, required 0", dual_ready - dr0);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit got, ok;
        int r0;
        logic [15:0] rd;
        rd = 16'($urandom);
        phy_word[1]  = rd;
        req_wr[1]    = 1'b0;
        req_phy[1]   = 5'h03;
        req_reg[1]   = 5'h02;
        req_wdata[1] = 16'h0;
        req_valid[1] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 * MDC_DIV; i++) begin
            @(negedge clk);
            if (req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        req_valid[1] = 1'b0;
        checks++;
        if (!got) $display("FAIL abort_grant_timeout: ready=0, required 1");
        else passed++;

        // run up to the rise of DATA bit 5
        ok = 1'b1;
        for (int i = 0; i < PRE_BITS + 16 + 6 && ok; i++) wait_mdc_rise(ok);
        checks++;
        if (!ok || phy_mdio_tri !== 1'b0)
            $display("FAIL abort_in_data: ok=%0d tri=%b, required ok=1 tri=0", ok, phy_mdio_tri);
        else passed++;

        r0 = rsp_cnt[1];
        reset = 1'b1;
        #1;
        checks++;
        if ({phy_mdc, phy_mdio_out, phy_mdio_tri, busy, req0_ready, req1_ready,
             rsp0_valid, rsp1_valid} !== 8'b01000000)
            $display("FAIL abort_reset_outputs: got %b, required 01000000",
                     {phy_mdc, phy_mdio_out, phy_mdio_tri, busy, req0_ready, req1_ready,
                      rsp0_valid, rsp1_valid});
        else passed++;
        checks++;
        if ({rsp0_rdata, rsp1_rdata} !== 32'h0)
            $display("FAIL abort_reset_rdata: got %h, required 0", {rsp0_rdata, rsp1_rdata});
        else passed++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40 * MDC_DIV) @(negedge clk);
        checks++;
        if (rsp_cnt[1] !== r0)
            $display("FAIL abort_no_rsp: got %0d pulses, required 0", rsp_cnt[1] - r0);
        else passed++;

        do_txn(1, 1'b0, 5'h1F, 5'h11, 16'h0, 16'($urandom));
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_phy[i]   = 5'h0;
            req_reg[i]   = 5'h0;
            req_wdata[i] = 16'h0;
        end
        test_reset();
        test_write_directed();
        test_read_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 Parameter MDC_DIV, default 13, core-clock cycles per MDC half-period (2.4 MHz MDC from 62.5 MHz clk); legal range 2..255.
REQ-002 clk  input  1  core clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N has an MDIO transaction pending.
REQ-005 reqN_ready  output  1  single-cycle grant pulse; the transaction is accepted when reqN_valid and reqN_ready are both high.
REQ-006 reqN_wr  input  1  1 = write, 0 = read.
REQ-007 reqN_phy  input  5  PHY address.
REQ-008 reqN_reg  input  5  register address.
REQ-009 reqN_wdata  input  16  write data.
REQ-010 rspN_valid  output  1  single-cycle completion pulse to requester N.
REQ-011 rspN_rdata  output  16  read data, valid with rspN_valid; 0 for writes.
REQ-012 phy_mdc  output  1  management data clock.
REQ-013 phy_mdio_out  output  1  serial data to the pad.
REQ-014 phy_mdio_tri  output  1  1 = drive phy_mdio_out onto the pad, 0 = release the pad.
REQ-015 phy_mdio_in  input  1  pad input.
REQ-016 busy  output  1  high from acceptance until the response pulse.

Function
REQ-017 phy_mdc SHALL run free after reset, toggling every MDC_DIV clk cycles and starting low.
REQ-018 The block SHALL change phy_mdio_out and phy_mdio_tri only in the clk cycle in which phy_mdc falls, and SHALL sample phy_mdio_in in the cycle in which phy_mdc rises.
REQ-019 States SHALL be IDLE, PRE, HDR, TA, DATA, GAP. Transitions: IDLE->PRE on acceptance; PRE->HDR after 32 bits; HDR->TA after 14 bits; TA->DATA after 2 bits; DATA->GAP after 16 bits; GAP->IDLE after 1 bit.
REQ-020 HDR SHALL send, MSB first: ST=01; OP=01 for a write or 10 for a read; then PHY[4:0] and REG[4:0].
REQ-021 For a write, TA SHALL drive 10 and DATA SHALL drive wdata MSB first with tri=1.
REQ-022 For a read, tri SHALL be 0 from the start of TA to the end of DATA; the 16 DATA samples SHALL shift in MSB first.
REQ-023 In GAP the block SHALL hold tri=0 and out=1, and SHALL pulse rspN_valid with rspN_rdata for the owning requester in the first clk cycle of GAP.
REQ-024 Arbitration SHALL occur only in IDLE, aligned to an MDC falling-edge cycle.
- Only one valid: that requester is granted.
- Both valid: round-robin; the requester not served last wins.
- After reset, requester 0 has priority.
REQ-025 At most one reqN_ready SHALL pulse per transaction; requester fields SHALL be latched in the grant cycle and are don't-care afterwards.
REQ-026 A request made while busy SHALL stay pending, with ready low; the requester SHALL hold valid.
REQ-027 A frame SHALL always complete once started; there is no abort input.

Reset
REQ-028 On reset assertion, all outputs SHALL go immediately to: phy_mdc=0, phy_mdio_out=1, phy_mdio_tri=0, reqN_ready=0, rspN_valid=0, rspN_rdata=0, busy=0.
REQ-029 On reset assertion, state SHALL return to IDLE and the round-robin pointer SHALL favour requester 0.
REQ-030 Reset mid-frame SHALL abort the frame with no rspN_valid pulse; the next frame SHALL start with a full PRE (when compiled in).

Configuration
REQ-031 With macro MDIO_PREAMBLE_EN defined, the PRE state SHALL send 32 ones with tri=1; a frame then spans 65 MDC periods including GAP.
REQ-032 Without MDIO_PREAMBLE_EN, the PRE state SHALL be skipped (IDLE->HDR directly); a frame then spans 33 MDC periods.

Verification
REQ-033 PREAMBLE_EN, MDC_DIV=13: req0 write phy=0x01 reg=0x00 wdata=0x1140 -> pad bits 32x1, 01 01 00001 00000 10 0001000101000000; rsp0_valid pulses once; rsp0_rdata=0.
REQ-034 req1 read phy=0x04 reg=0x01; PHY model drives 0x796D -> tri=0 over TA and DATA; rsp1_rdata=0x796D; phy_mdc period is 26 clk cycles.
REQ-035 req0 and req1 both valid from reset, each held for 3 transactions -> grant order 0,1,0,1,0,1; busy never deasserts between a grant and its response.
REQ-036 reset asserted during DATA bit 5 of a read -> outputs take their reset values that cycle; no rsp pulse occurs; the next request produces a complete, correct frame.
REQ-037 MDIO_PREAMBLE_EN undefined: single write -> first driven bits are 01, the frame is 33 MDC periods, and rsp0_valid falls 33x26 clk cycles after the first post-grant MDC fall (±1 MDC period).
